// File: rtl/phy_rx_deframer.sv
// Serial receive deframer: hunts for COM alignment, locks after repeated COMs,
// and reassembles 9-bit {k,d} symbols (MSB first) into 32-bit words.
module phy_rx_deframer #(
    parameter logic [7:0]  COM        = 8'hBC,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned LOSS_COUNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_in,
    output logic [31:0] output_bus,
    output logic        valid_out,
    output logic        active,
    output logic        error
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT = 4'(LOSS_COUNT);

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [3:0]  bitpos_q, bitpos_d;
    logic [3:0]  comcnt_q, comcnt_d;
    logic [3:0]  badcnt_q, badcnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] part_q, part_d;
    logic [31:0] bus_q, bus_d;
    logic        valid_q, valid_d;
    logic        active_q, active_d;
    logic        error_q, error_d;

    // The candidate symbol includes the bit being sampled on this edge.
    logic [8:0] sym_s;
    logic       is_com_s;
    logic       is_data_s;
    logic       sym_done_s;

    assign sym_s      = {sh_q, serial_in};
    assign is_com_s   = (sym_s == {1'b1, COM});
    assign is_data_s  = ~sym_s[8];
    assign sym_done_s = (bitpos_q == 4'd8);

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= SEARCH;
            sh_q     <= 8'h00;
            bitpos_q <= 4'd0;
            comcnt_q <= 4'd0;
            badcnt_q <= 4'd0;
            idx_q    <= 2'd0;
            part_q   <= 24'h000000;
            bus_q    <= 32'h00000000;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_q     <= sh_d;
            bitpos_q <= bitpos_d;
            comcnt_q <= comcnt_d;
            badcnt_q <= badcnt_d;
            idx_q    <= idx_d;
            part_q   <= part_d;
            bus_q    <= bus_d;
            valid_q  <= valid_d;
            active_q <= active_d;
            error_q  <= error_d;
        end
    end

    // Next-state: alignment hunt, lock qualification and loss of lock.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SEARCH: begin
                if (is_com_s) begin
                    state_d = (LOCK_CNT == 4'd1) ? LOCKED : ALIGN;
                end else begin
                    state_d = SEARCH;
                end
            end
            ALIGN: begin
                if (sym_done_s) begin
                    if (is_com_s) begin
                        state_d = ((comcnt_q + 4'd1) == LOCK_CNT) ? LOCKED : ALIGN;
                    end else begin
                        state_d = SEARCH;
                    end
                end else begin
                    state_d = ALIGN;
                end
            end
            LOCKED: begin
                if (sym_done_s && !is_com_s && !is_data_s &&
                    ((badcnt_q + 4'd1) == LOSS_CNT)) begin
                    state_d = SEARCH;
                end else begin
                    state_d = LOCKED;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    // Counters, word assembly and registered output pulses.
    always_comb begin
        sh_d     = {sh_q[6:0], serial_in};
        bitpos_d = sym_done_s ? 4'd0 : (bitpos_q + 4'd1);
        comcnt_d = comcnt_q;
        badcnt_d = badcnt_q;
        idx_d    = idx_q;
        part_d   = part_q;
        bus_d    = bus_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        active_d = (state_d == LOCKED);
        case (state_q)
            SEARCH: begin
                if (is_com_s) begin
                    bitpos_d = 4'd0;
                    comcnt_d = 4'd1;
                    badcnt_d = 4'd0;
                    idx_d    = 2'd0;
                end else begin
                    comcnt_d = 4'd0;
                end
            end
            ALIGN: begin
                if (sym_done_s) begin
                    comcnt_d = is_com_s ? (comcnt_q + 4'd1) : 4'd0;
                end else begin
                    comcnt_d = comcnt_q;
                end
            end
            LOCKED: begin
                if (!sym_done_s) begin
                    idx_d = idx_q;
                end else if (is_com_s) begin
                    error_d  = (idx_q != 2'd0);
                    idx_d    = 2'd0;
                    badcnt_d = 4'd0;
                end else if (is_data_s) begin
                    badcnt_d = 4'd0;
                    idx_d    = idx_q + 2'd1;
                    case (idx_q)
                        2'd0:    part_d[23:16] = sym_s[7:0];
                        2'd1:    part_d[15:8]  = sym_s[7:0];
                        2'd2:    part_d[7:0]   = sym_s[7:0];
                        2'd3: begin
                            bus_d   = {part_q, sym_s[7:0]};
                            valid_d = 1'b1;
                        end
                        default: part_d = part_q;
                    endcase
                end else begin
                    // Invalid control symbol: drop the partial word, count toward loss.
                    error_d = 1'b1;
                    idx_d   = 2'd0;
                    if ((badcnt_q + 4'd1) == LOSS_CNT) begin
                        badcnt_d = 4'd0;
                        comcnt_d = 4'd0;
                    end else begin
                        badcnt_d = badcnt_q + 4'd1;
                    end
                end
            end
            default: begin
                comcnt_d = 4'd0;
                badcnt_d = 4'd0;
                idx_d    = 2'd0;
            end
        endcase
    end

    assign output_bus = bus_q;
    assign valid_out  = valid_q;
    assign active     = active_q;
    assign error      = error_q;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Scoreboard bench for phy_rx_deframer: serial symbol stimulus, expected words queued on send.
module tb_phy_rx_deframer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        serial_in = 1'b0;
    logic [31:0] output_bus;
    logic        valid_out;
    logic        active;
    logic        error;

    localparam logic [8:0] COM_SYM = 9'h1BC;
    localparam logic [8:0] BAD_SYM = 9'h1FF;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          vcnt = 0;
    int          ecnt = 0;
    int          last_vcyc = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    phy_rx_deframer dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .output_bus (output_bus),
        .valid_out  (valid_out),
        .active     (active),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard on every valid_out pulse.
    always @(posedge clk) begin
        #1;
        if (valid_out === 1'b1) begin
            vcnt++;
            last_vcyc = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: valid_out with output_bus=%h, required no pulse", output_bus);
            end else begin
                exp_w = exp_q.pop_front();
                if (output_bus !== exp_w) begin
                    n_bad++;
                    $display("FAIL sb_word: got %h, expected %h", output_bus, exp_w);
                end
            end
        end
        if (error === 1'b1) ecnt++;
        if (valid_out === 1'b1 || error === 1'b1) begin
            n_cmp++;
            if (valid_out === 1'b1 && error === 1'b1) begin
                n_bad++;
                $display("FAIL excl: valid_out=%b error=%b, required not both 1", valid_out, error);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past 200000 time units");
        $fatal(1, "timeout");
    end

    task automatic send_sym(input logic [8:0] s);
        for (int i = 8; i >= 0; i--) begin
            @(negedge clk);
            serial_in = s[i];
        end
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_q.push_back(w);
        for (int i = 3; i >= 0; i--) send_sym({1'b0, w[i*8 +: 8]});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if (output_bus !== 32'h0 || valid_out !== 1'b0 || active !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: bus=%h valid=%b active=%b error=%b, required all 0",
                     output_bus, valid_out, active, error);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < 4; i++) begin
            send_sym(COM_SYM);
            n_cmp++;
            if (active !== (i == 3 ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL lock_active: after COM %0d active=%b, required %b", i + 1, active, (i == 3));
            end
        end
        n_cmp++;
        if (vcnt != 0 || ecnt != 0 || output_bus !== 32'h0) begin
            n_bad++;
            $display("FAIL lock_quiet: vpulses=%0d epulses=%0d bus=%h, required 0/0/0", vcnt, ecnt, output_bus);
        end
    endtask

    task automatic test_word();
        int v0;
        v0 = vcnt;
        send_word(32'hDEADBEEF);
        n_cmp++;
        if (valid_out !== 1'b1 || output_bus !== 32'hDEADBEEF || last_vcyc != cyc) begin
            n_bad++;
            $display("FAIL word_edge: valid=%b bus=%h pulse_cyc=%0d, required 1/DEADBEEF/%0d",
                     valid_out, output_bus, last_vcyc, cyc);
        end
        for (int i = 0; i < 5; i++) send_sym(COM_SYM);
        n_cmp++;
        if (vcnt != v0 + 1 || output_bus !== 32'hDEADBEEF || active !== 1'b1) begin
            n_bad++;
            $display("FAIL word_hold: vpulses=%0d bus=%h active=%b, required %0d/DEADBEEF/1",
                     vcnt - v0, output_bus, active, 1);
        end
    endtask

    task automatic test_back_to_back();
        int c1;
        int e0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            serial_in = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 4; i++) send_sym(COM_SYM);
        n_cmp++;
        if (active !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_lock: active=%b, required 1", active);
        end
        e0 = ecnt;
        send_word(32'h01020304);
        c1 = last_vcyc;
        send_word(32'hBCBCBCBC);
        n_cmp++;
        if (last_vcyc - c1 != 36 || output_bus !== 32'hBCBCBCBC || exp_q.size() != 0 || ecnt != e0) begin
            n_bad++;
            $display("FAIL b2b_spacing: gap=%0d bus=%h pending=%0d errs=%0d, required 36/BCBCBCBC/0/0",
                     last_vcyc - c1, output_bus, exp_q.size(), ecnt - e0);
        end
    endtask

    task automatic test_truncated();
        int e0;
        int v0;
        e0 = ecnt;
        v0 = vcnt;
        send_sym({1'b0, 8'h11});
        send_sym({1'b0, 8'h22});
        send_sym(COM_SYM);
        n_cmp++;
        if (error !== 1'b1 || valid_out !== 1'b0) begin
            n_bad++;
            $display("FAIL trunc_pulse: error=%b valid=%b, required 1/0", error, valid_out);
        end
        send_word(32'hCAFEF00D);
        n_cmp++;
        if (ecnt != e0 + 1 || vcnt != v0 + 1 || output_bus !== 32'hCAFEF00D) begin
            n_bad++;
            $display("FAIL trunc_next: epulses=%0d vpulses=%0d bus=%h, required 1/1/CAFEF00D",
                     ecnt - e0, vcnt - v0, output_bus);
        end
    endtask

    task automatic test_loss();
        int e0;
        e0 = ecnt;
        for (int i = 0; i < 4; i++) begin
            send_sym(BAD_SYM);
            n_cmp++;
            if (error !== 1'b1 || active !== (i < 3 ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL loss_bad: sym %0d error=%b active=%b, required 1/%b", i + 1, error, active, (i < 3));
            end
        end
        for (int i = 0; i < 4; i++) begin
            send_sym(COM_SYM);
            n_cmp++;
            if (active !== (i == 3 ? 1'b1 : 1'b0)) begin
                n_bad++;
                $display("FAIL loss_relock: COM %0d active=%b, required %b", i + 1, active, (i == 3));
            end
        end
        n_cmp++;
        if (ecnt != e0 + 4) begin
            n_bad++;
            $display("FAIL loss_errs: epulses=%0d, required 4", ecnt - e0);
        end
    endtask

    task automatic test_reset_midword();
        int v0;
        send_sym({1'b0, 8'hAA});
        send_sym({1'b0, 8'h55});
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if (output_bus !== 32'h0 || valid_out !== 1'b0 || active !== 1'b0 || error !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_async: bus=%h valid=%b active=%b error=%b, required all 0",
                     output_bus, valid_out, active, error);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        v0 = vcnt;
        send_sym({1'b0, 8'h11});
        send_sym({1'b0, 8'h22});
        send_sym({1'b0, 8'h33});
        send_sym({1'b0, 8'h44});
        n_cmp++;
        if (vcnt != v0 || active !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_untrained: vpulses=%0d active=%b, required 0/0", vcnt - v0, active);
        end
        for (int i = 0; i < 4; i++) send_sym(COM_SYM);
        send_word(32'h0BADC0DE);
        n_cmp++;
        if (vcnt != v0 + 1 || exp_q.size() != 0 || output_bus !== 32'h0BADC0DE) begin
            n_bad++;
            $display("FAIL rst_retrain: vpulses=%0d pending=%0d bus=%h, required 1/0/0BADC0DE",
                     vcnt - v0, exp_q.size(), output_bus);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_word();
        test_back_to_back();
        test_truncated();
        test_loss();
        test_reset_midword();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
